// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (iterative shift-and-add-3, "double dabble").
// One binary bit is consumed per clock. The four-digit packed BCD result is
// presented on bcd, with a start/busy/done handshake around each conversion.
// The last result is held between conversions so a downstream display stays stable.
// Optional feature macro: BCD_OVF_SAT_EN. When it is defined, values above 9999
// saturate to 9999. Otherwise those values wrap modulo 10000. In both builds
// ovf is raised for values above 9999.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin,
  input  logic             start,
  output logic [15:0]      bcd,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int unsigned DIGITS = 5;
  localparam int unsigned ACC_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
  localparam int unsigned CAT_W  = ACC_W + BIN_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   sh;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;

  logic [ACC_W-1:0]   acc_adj;
  logic [CAT_W-1:0]   cat_shl;
  logic [15:0]        result_c;
  logic               ovf_c;

  // Add 3 to every accumulator digit that is 5 or more, all digits in parallel.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // Shift the adjusted accumulator and the binary shift register left as one word.
  always_comb begin
    cat_shl = {acc_adj, sh} << 1;
  end

  // Final digit selection. The top digit D4 is nonzero only for values above 9999.
  always_comb begin
    ovf_c = |acc[ACC_W-1:16];
`ifdef BCD_OVF_SAT_EN
    result_c = ovf_c ? 16'h9999 : acc[15:0];
`else
    result_c = acc[15:0];
`endif
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= 16'h0000;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sh    <= bin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc <= cat_shl[CAT_W-1:BIN_W];
          sh  <= cat_shl[BIN_W-1:0];
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd   <= result_c;
          ovf   <= ovf_c;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (default BIN_W = 14).
// Expected results are queued on each start and popped when done pulses.
module tb_bin_to_bcd_seq;

  localparam int unsigned BIN_W = 14;
  localparam int unsigned LAT   = BIN_W + 1;
  localparam int unsigned PER   = BIN_W + 2;

  logic             clk;
  logic             rst;
  logic [BIN_W-1:0] bin;
  logic             start;
  logic [15:0]      bcd;
  logic             busy;
  logic             done;
  logic             ovf;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bin   (bin),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int unsigned v);
    exp_t        e;
    int unsigned r;
    e.ovf = (v > 9999);
`ifdef BCD_OVF_SAT_EN
    r = e.ovf ? 9999 : v;
`else
    r = v % 10000;
`endif
    e.bcd = {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bcd !== 16'h0000) begin n_err++; $display("FAIL reset_bcd got=%h want=0000", bcd); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Single conversion of 1234 with cycle-exact busy/done/bcd checks.
  task automatic test_timing();
    exp_t e;
    exp_t got;
    logic [15:0] prev;
    prev = bcd;
    bin = 14'd1234; start = 1'b1;
    sb.push_back(model(1234));
    @(negedge clk);           // just after accept edge k
    start = 1'b0;
    for (int j = 0; j <= int'(LAT); j++) begin
      if (j > 0) @(negedge clk);
      n_cmp++;
      if (busy !== (j < int'(LAT))) begin n_err++; $display("FAIL timing_busy j=%0d got=%b want=%b", j, busy, (j < int'(LAT))); end
      n_cmp++;
      if (done !== (j == int'(LAT))) begin n_err++; $display("FAIL timing_done j=%0d got=%b want=%b", j, done, (j == int'(LAT))); end
      if (j < int'(LAT)) begin
        n_cmp++;
        if (bcd !== prev) begin n_err++; $display("FAIL timing_hold j=%0d got=%h want=%h", j, bcd, prev); end
      end else begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL timing_sb_empty got=empty want=entry");
        end else begin
          e = sb.pop_front();
          got.bcd = bcd; got.ovf = ovf;
          n_cmp++;
          if (got !== e) begin n_err++; $display("FAIL timing_result got=%h/%b want=%h/%b", bcd, ovf, e.bcd, e.ovf); end
        end
      end
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL timing_done_pulse got=%b want=0", done); end
  endtask

  // Boundary and overflow values, one conversion each.
  task automatic test_values();
    int unsigned vals [12] = '{0, 9999, 10, 10000, 16383, 1, 99, 100, 999, 1000, 5555, 12345};
    exp_t e;
    bit   seen;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bin = BIN_W'(vals[i]); start = 1'b1;
      sb.push_back(model(vals[i]));
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      if (!seen) begin
        n_cmp++; n_err++; $display("FAIL values_timeout v=%0d got=no_done want=done", vals[i]);
        sb.delete();
      end else if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (bcd !== e.bcd) begin n_err++; $display("FAIL values_bcd v=%0d got=%h want=%h", vals[i], bcd, e.bcd); end
        n_cmp++;
        if (ovf !== e.ovf) begin n_err++; $display("FAIL values_ovf v=%0d got=%b want=%b", vals[i], ovf, e.ovf); end
      end
    end
  endtask

  // A start pulse during a conversion must be ignored.
  task automatic test_ignore();
    exp_t e;
    logic [15:0] prev;
    bit extra;
    @(negedge clk);
    prev = bcd;
    bin = 14'd42; start = 1'b1;
    sb.push_back(model(42));
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= int'(LAT); j++) begin
      @(negedge clk);
      if (j == 4) begin bin = 14'd77; start = 1'b1; end
      if (j == 5) begin start = 1'b0; bin = 14'd0; end
      if (j < int'(LAT)) begin
        n_cmp++;
        if (bcd !== prev || done !== 1'b0) begin
          n_err++; $display("FAIL ignore_hold j=%0d got=%h/%b want=%h/0", j, bcd, done, prev);
        end
      end else begin
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL ignore_done got=%b want=1", done); end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          n_cmp++;
          if (bcd !== e.bcd) begin n_err++; $display("FAIL ignore_bcd got=%h want=%h", bcd, e.bcd); end
        end
      end
    end
    extra = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) extra = 1'b1;
    end
    n_cmp++;
    if (extra) begin n_err++; $display("FAIL ignore_extra got=activity want=idle"); end
    n_cmp++;
    if (bcd !== 16'h0042) begin n_err++; $display("FAIL ignore_final got=%h want=0042", bcd); end
  endtask

  // Asynchronous reset in the middle of a conversion, then recovery.
  task automatic test_reset_mid();
    exp_t e;
    bit   seen;
    @(negedge clk);
    bin = 14'd1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (int'(LAT)) @(negedge clk);
    n_cmp++;
    if (bcd !== 16'h1234) begin n_err++; $display("FAIL rstmid_pre got=%h want=1234", bcd); end
    @(negedge clk);
    bin = 14'd5678; start = 1'b1;
    sb.push_back(model(5678));
    @(negedge clk);           // after edge k
    start = 1'b0;
    repeat (6) @(negedge clk); // after edge k+6
    @(posedge clk);           // edge k+7
    #2 rst = 1'b1;
    #1;
    sb.delete();
    n_cmp++; if (bcd !== 16'h0000) begin n_err++; $display("FAIL rstmid_bcd got=%h want=0000", bcd); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%b want=0", done); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bin = 14'd5678; start = 1'b1;
    sb.push_back(model(5678));
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL rstmid_timeout got=no_done want=done");
      sb.delete();
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      if (bcd !== e.bcd) begin n_err++; $display("FAIL rstmid_bcd_after got=%h want=%h", bcd, e.bcd); end
    end
  endtask

  // start held high: one conversion every PER cycles, each re-sampling bin.
  task automatic test_back_to_back();
    exp_t e;
    int   nconv;
    nconv = 21;
    @(negedge clk);
    bin = 14'd0; start = 1'b1;
    sb.push_back(model(0));
    for (int j = 0; j < nconv * int'(PER); j++) begin
      @(negedge clk);
      if ((j % int'(PER)) == 0 && (j / int'(PER)) < nconv - 1) begin
        bin = BIN_W'(j / int'(PER) + 1);
        sb.push_back(model(unsigned'(j / int'(PER) + 1)));
      end
      if (j == nconv * int'(PER) - 1) start = 1'b0;
      n_cmp++;
      if (done !== ((j % int'(PER)) == int'(LAT))) begin
        n_err++; $display("FAIL b2b_done j=%0d got=%b want=%b", j, done, ((j % int'(PER)) == int'(LAT)));
      end
      if ((j % int'(PER)) == int'(LAT)) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL b2b_sb_empty j=%0d got=empty want=entry", j);
        end else begin
          e = sb.pop_front();
          n_cmp++;
          if (bcd !== e.bcd || ovf !== e.ovf) begin
            n_err++; $display("FAIL b2b_result j=%0d got=%h/%b want=%h/%b", j, bcd, ovf, e.bcd, e.ovf);
          end
        end
      end
    end
    start = 1'b0;
    repeat (PER) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL b2b_leftover got=%0d want=0", sb.size()); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_timing();
    test_values();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
